// File: rtl/pt2262_encoder.sv
// PT2262-compatible remote-control encoder: serialises 8 address trits and 4 data
// bits plus a sync word into the classic pulse-width waveform, repeated in bursts.
module pt2262_encoder #(
    parameter int ALPHA_DIV  = 250,
    parameter int MIN_FRAMES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] A,
    input  logic [3:0]  D,
    input  logic        te,
    output logic        cod_o,
    output logic        busy,
    output logic        frame_done
);
    localparam int AW = (ALPHA_DIV > 1) ? $clog2(ALPHA_DIV) : 1;
    localparam int FW = $clog2(MIN_FRAMES + 1);
    localparam logic [AW-1:0] ALPHA_LAST = AW'(ALPHA_DIV - 1);
    localparam logic [FW-1:0] FRAMES_MIN = FW'(MIN_FRAMES);

    typedef enum logic [1:0] {IDLE, CODE, SYNC} state_t;

    state_t        state, state_next;
    logic [AW-1:0] alpha_cnt;
    logic [6:0]    unit_cnt;   // α units inside the current pulse (0..15) or sync word (0..127)
    logic          pulse_idx;
    logic [3:0]    sym_idx;
    logic [FW-1:0] frame_cnt;
    logic [15:0]   a_reg;
    logic [3:0]    d_reg;

    logic          alpha_tick, pulse_end, code_end, sync_end, frame_start;
    logic [FW-1:0] frame_cnt_inc;
    logic [1:0]    trit;
    logic          long_pulse, cod_next;

    assign alpha_tick    = (alpha_cnt == ALPHA_LAST);
    assign pulse_end     = alpha_tick && (unit_cnt == 7'd15);
    assign code_end      = (state == CODE) && pulse_end && pulse_idx && (sym_idx == 4'd11);
    assign sync_end      = (state == SYNC) && alpha_tick && (unit_cnt == 7'd127);
    assign frame_start   = (state == CODE) && (sym_idx == 4'd0) && !pulse_idx &&
                           (unit_cnt == 7'd0) && (alpha_cnt == '0);
    assign frame_cnt_inc = (frame_cnt == FRAMES_MIN) ? frame_cnt : frame_cnt + FW'(1);

    // Data bits are binary symbols, so they map onto the trits 00 / 11.
    always_comb begin
        trit = 2'b00;
        if (sym_idx < 4'd8) trit = a_reg[{sym_idx[2:0], 1'b0} +: 2];
        else                trit = {2{d_reg[sym_idx[1:0]]}};
    end

    // Floating trit (01/10) is a short pulse followed by a long one.
    assign long_pulse = (trit == 2'b11) || ((trit[1] ^ trit[0]) && pulse_idx);

    always_comb begin
        cod_next = 1'b0;
        case (state)
            CODE:    cod_next = long_pulse ? (unit_cnt < 7'd12) : (unit_cnt < 7'd4);
            SYNC:    cod_next = (unit_cnt < 7'd4);
            default: cod_next = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (te) state_next = CODE;
            CODE:    if (code_end) state_next = SYNC;
            SYNC:    if (sync_end) state_next = (te || (frame_cnt_inc < FRAMES_MIN)) ? CODE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alpha_cnt <= '0;
            unit_cnt  <= '0;
            pulse_idx <= 1'b0;
            sym_idx   <= '0;
        end else if (state == IDLE) begin
            alpha_cnt <= '0;
            unit_cnt  <= '0;
            pulse_idx <= 1'b0;
            sym_idx   <= '0;
        end else begin
            alpha_cnt <= alpha_tick ? '0 : alpha_cnt + AW'(1);
            if (code_end || sync_end) begin
                unit_cnt  <= '0;
                pulse_idx <= 1'b0;
                sym_idx   <= '0;
            end else if ((state == CODE) && pulse_end) begin
                unit_cnt  <= '0;
                pulse_idx <= !pulse_idx;
                if (pulse_idx) sym_idx <= sym_idx + 4'd1;
            end else if (alpha_tick) begin
                unit_cnt <= unit_cnt + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            a_reg     <= '0;
            d_reg     <= '0;
        end else begin
            if (sync_end) frame_cnt <= (state_next == IDLE) ? '0 : frame_cnt_inc;
            if (frame_start) begin
                a_reg <= A;
                d_reg <= D;
            end
        end
    end

    // NOTE: outputs are registered from the current counters, so they trail the
    // internal state by exactly one cycle and never see A/D/te combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cod_o      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cod_o      <= cod_next;
            busy       <= (state != IDLE);
            frame_done <= sync_end;
        end
    end
endmodule

// File: tb/tb_pt2262_encoder.sv
// Scoreboard bench for pt2262_encoder: stimulus queues expected pulse runs and
// burst summaries, monitors measure cod_o/busy/frame_done and compare.
`timescale 1ns/1ps
module tb_pt2262_encoder;
    localparam int ADIV  = 3;
    localparam int MINF  = 4;
    localparam int FRAME = 512 * ADIV;

    logic        clk = 1'b0;
    logic        reset, te;
    logic [15:0] A;
    logic [3:0]  D;
    logic        cod_o, busy, frame_done;

    pt2262_encoder #(.ALPHA_DIV(ADIV), .MIN_FRAMES(MINF)) dut (
        .clk(clk), .reset(reset), .A(A), .D(D), .te(te),
        .cod_o(cod_o), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic level;
        int   len;
    } run_t;

    run_t run_q[$];
    int   burst_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic push_run(input logic lvl, input int units);
        run_t r;
        r.level = lvl;
        r.len   = units * ADIV;
        run_q.push_back(r);
    endtask

    task automatic push_frame(input logic [15:0] a, input logic [3:0] d);
        logic [1:0] t;
        bit         lng;
        for (int s = 0; s < 12; s++) begin
            t = (s < 8) ? a[2*s +: 2] : {2{d[s-8]}};
            for (int p = 0; p < 2; p++) begin
                lng = (t == 2'b11) || ((t == 2'b01 || t == 2'b10) && p == 1);
                push_run(1'b1, lng ? 12 : 4);
                push_run(1'b0, lng ? 4 : 12);
            end
        end
        push_run(1'b1, 4);
        push_run(1'b0, 124);
    endtask

    // First frame carries a1/d1, the remaining ones a2/d2.
    task automatic push_burst(input logic [15:0] a1, input logic [3:0] d1,
                              input logic [15:0] a2, input logic [3:0] d2, input int frames);
        push_frame(a1, d1);
        for (int f = 1; f < frames; f++) push_frame(a2, d2);
        burst_q.push_back(frames);
    endtask

    // Run monitor: measures every constant-level stretch of cod_o while busy.
    logic run_lvl;
    int   run_len = 0;
    bit   in_run = 1'b0;
    bit   b_active = 1'b0;
    int   b_len = 0;
    int   b_done = 0;

    task automatic close_run();
        run_t e;
        if (run_q.size() == 0) begin
            check("run_unexpected_len", run_len, 0);
        end else begin
            e = run_q.pop_front();
            check("run_level", run_lvl, e.level);
            check("run_len", run_len, e.len);
        end
    endtask

    task automatic close_burst();
        int f;
        if (burst_q.size() == 0) begin
            check("burst_unexpected_len", b_len, 0);
        end else begin
            f = burst_q.pop_front();
            check("busy_len", b_len, f * FRAME);
            check("done_count", b_done, f);
        end
    endtask

    always @(negedge clk) begin
        if (!mon_en) begin
            in_run   = 1'b0;
            b_active = 1'b0;
        end else if (busy === 1'b1) begin
            if (in_run && cod_o === run_lvl) begin
                run_len++;
            end else begin
                if (in_run) close_run();
                in_run  = 1'b1;
                run_lvl = cod_o;
                run_len = 1;
            end
            if (!b_active) begin
                b_active = 1'b1;
                b_len    = 0;
                b_done   = 0;
            end
            if (frame_done === 1'b1) begin
                b_done++;
                check("done_position", (b_len + 1) % FRAME, 0);
            end
            b_len++;
        end else begin
            if (in_run) begin
                close_run();
                in_run = 1'b0;
            end
            if (b_active) begin
                close_burst();
                b_active = 1'b0;
            end
            if (frame_done !== 1'b0) check("done_outside_busy", frame_done, 0);
        end
    end

    task automatic pulse_te();
        @(negedge clk);
        te = 1'b1;
        @(negedge clk);
        te = 1'b0;
    endtask

    task automatic wait_burst(input string name, input int budget);
        int n = 0;
        while (busy !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b1) check({name, "_no_start"}, busy, 1);
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) check({name, "_timeout"}, busy, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int dones, busy_seen;

        // Reset held with te=1: outputs stay low, start one cycle after release edge.
        reset = 1'b1;
        te    = 1'b1;
        A     = 16'h0000;
        D     = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_cod", cod_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        push_burst(16'h0000, 4'h0, 16'h0000, 4'h0, MINF);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("edge_k_cod", cod_o, 0);
        check("edge_k_busy", busy, 0);
        te = 1'b0;
        @(posedge clk);
        #1;
        check("edge_k1_cod", cod_o, 1);
        check("edge_k1_busy", busy, 1);
        wait_burst("zeros", 5 * FRAME);

        // All-ones address and data.
        A = 16'hFFFF;
        D = 4'hF;
        push_burst(A, D, A, D, MINF);
        pulse_te();
        wait_burst("ones", 5 * FRAME);

        // Mixed trits, including both floating encodings in trits 0 and 1.
        A = 16'h72C6;
        D = 4'hA;
        push_burst(A, D, A, D, MINF);
        pulse_te();
        wait_burst("mixed", 5 * FRAME);

        // te held high across five frame ends: six back-to-back frames.
        A = 16'h5A0F;
        D = 4'h3;
        push_burst(A, D, A, D, 6);
        @(negedge clk);
        te    = 1'b1;
        dones = 0;
        for (int n = 0; n < 7 * FRAME && dones < 5; n++) begin
            @(negedge clk);
            if (frame_done === 1'b1) dones++;
        end
        check("held_te_dones", dones, 5);
        te = 1'b0;
        wait_burst("held", 3 * FRAME);

        // A/D changed mid-frame: only later frames carry the new values.
        A = 16'hC3C3;
        D = 4'h5;
        push_burst(16'hC3C3, 4'h5, 16'h9D21, 4'hC, MINF);
        pulse_te();
        repeat (700) @(negedge clk);
        A = 16'h9D21;
        D = 4'hC;
        wait_burst("midchange", 5 * FRAME);

        // Reset in the middle of a frame aborts it silently.
        mon_en = 1'b0;
        A = 16'hFFFF;
        D = 4'hF;
        pulse_te();
        repeat (600) @(negedge clk);
        check("abort_busy_before", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_cod", cod_o, 0);
        check("abort_busy", busy, 0);
        check("abort_done", frame_done, 0);
        repeat (3) @(negedge clk);
        reset     = 1'b0;
        dones     = 0;
        busy_seen = 0;
        for (int n = 0; n < 2 * FRAME; n++) begin
            @(negedge clk);
            if (frame_done !== 1'b0) dones++;
            if (busy !== 1'b0) busy_seen++;
        end
        check("abort_no_done", dones, 0);
        check("abort_stays_idle", busy_seen, 0);

        check("run_queue_left", run_q.size(), 0);
        check("burst_queue_left", burst_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
